// File: rtl/lj16_deserializer.sv
// lj16_deserializer
// Receives a 16-bit left-justified serial stream (MSB first, words framed by
// LRCK edges) and presents a coherent left/right pair on parallel outputs
// together with a one-cycle sample_valid strobe. All logic runs on rising bck.
// A left word is held back until its matching right word arrives, so both
// parallel outputs always change together.
// Optional feature macro: LJ16_FRAME_CHECK_EN enables short/long word
// detection (sticky frame_err plus saturating err_count). With the macro
// undefined both outputs are tied to zero and the data path is unchanged.
module lj16_deserializer #(
   parameter int WIDTH      = 16,
   parameter int LEFT_LEVEL = 1
) (
   input  logic             bck,
   input  logic             rst_n,
   input  logic             lrck,
   input  logic             data,
   output logic [WIDTH-1:0] left_data,
   output logic [WIDTH-1:0] right_data,
   output logic             sample_valid,
   output logic             frame_err,
   output logic [7:0]       err_count
);

   localparam logic [4:0] LP_WIDTH = 5'(WIDTH);
   localparam logic       LP_LEFT  = 1'(LEFT_LEVEL);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic             r_lrck_d;
   logic [WIDTH-1:0] r_shift;
   logic [4:0]       r_cnt;
   logic             r_is_left;
   logic [WIDTH-1:0] r_left_hold;
   logic             r_left_ok;
   logic [WIDTH-1:0] r_left_data;
   logic [WIDTH-1:0] r_right_data;
   logic             r_valid;

   logic             w_edge;
   logic [WIDTH-1:0] w_shift_next;
   logic [4:0]       w_cnt_next;
   logic             w_is_left_next;
   logic             w_take;
   logic             w_short;
   logic             w_complete;

   // An LRCK edge is any change of lrck relative to the previous rising bck.
   assign w_edge = (lrck != r_lrck_d);

   // State register.
   always_ff @(posedge bck) begin
      if (!rst_n) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state, shift/count update and word-complete detection.
   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_cnt_next     = r_cnt;
      w_is_left_next = r_is_left;
      w_take         = 1'b0;
      w_short        = 1'b0;
      w_complete     = 1'b0;
      if (w_edge) begin
         // Bit sampled on the edge is the MSB of a fresh word.
         w_shift_next   = {{(WIDTH-1){1'b0}}, data};
         w_cnt_next     = 5'd1;
         w_is_left_next = (lrck == LP_LEFT);
         w_take         = 1'b1;
         // Still collecting when the edge arrived: the old word was short.
         w_short        = (r_state == ST_SHIFT);
         w_state_next   = ST_SHIFT;
      end else if (r_state == ST_SHIFT) begin
         w_shift_next = {r_shift[WIDTH-2:0], data};
         w_cnt_next   = 5'(r_cnt + 5'd1);
         w_take       = 1'b1;
      end
      // Count never passes WIDTH: reaching it moves to DONE, which stops shifting.
      w_complete = w_take && (w_cnt_next == LP_WIDTH);
      if (w_complete) begin
         w_state_next = ST_DONE;
      end
   end

   // Word assembly, left holding register and pair output.
   always_ff @(posedge bck) begin
      if (!rst_n) begin
         r_lrck_d     <= lrck;
         r_shift      <= '0;
         r_cnt        <= 5'd0;
         r_is_left    <= 1'b0;
         r_left_hold  <= '0;
         r_left_ok    <= 1'b0;
         r_left_data  <= '0;
         r_right_data <= '0;
         r_valid      <= 1'b0;
      end else begin
         r_lrck_d  <= lrck;
         r_shift   <= w_shift_next;
         r_cnt     <= w_cnt_next;
         r_is_left <= w_is_left_next;
         r_valid   <= 1'b0;
         // A truncated left word cannot be paired with the next right word.
         if (w_short && r_is_left) begin
            r_left_ok <= 1'b0;
         end
         if (w_complete) begin
            if (w_is_left_next) begin
               r_left_hold <= w_shift_next;
               r_left_ok   <= 1'b1;
            end else if (r_left_ok) begin
               r_left_data  <= r_left_hold;
               r_right_data <= w_shift_next;
               r_valid      <= 1'b1;
               r_left_ok    <= 1'b0;
            end
         end
      end
   end

   assign left_data    = r_left_data;
   assign right_data   = r_right_data;
   assign sample_valid = r_valid;

`ifdef LJ16_FRAME_CHECK_EN
   logic       r_word_err;
   logic       r_frame_err;
   logic [7:0] r_err_count;
   logic       w_long;
   logic       w_err_event;

   // First extra bit after a complete word; later extra bits of the same
   // word are masked by r_word_err so each word is counted at most once.
   assign w_long      = !w_edge && (r_state == ST_DONE) && !r_word_err;
   assign w_err_event = w_short || w_long;

   // Sticky error flag and saturating error counter.
   always_ff @(posedge bck) begin
      if (!rst_n) begin
         r_word_err  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         if (w_edge) begin
            r_word_err <= 1'b0;
         end else if (w_long) begin
            r_word_err <= 1'b1;
         end
         if (w_err_event) begin
            r_frame_err <= 1'b1;
            if (r_err_count != 8'hFF) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end
      end
   end

   assign frame_err = r_frame_err;
   assign err_count = r_err_count;
`else
   assign frame_err = 1'b0;
   assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_lj16_deserializer.sv
// tb_lj16_deserializer
// Drives one serial stream into two deserializers (LEFT_LEVEL=1 and
// LEFT_LEVEL=0) and checks both every cycle against a word-level model,
// plus literal expectations for each directed scenario.
// Honours LJ16_FRAME_CHECK_EN for the error outputs.
module tb_lj16_deserializer;

`ifdef LJ16_FRAME_CHECK_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic        bck;
   logic        rst_n;
   logic        lrck;
   logic        data;

   logic [15:0] l1, r1, l0, r0;
   logic        v1, v0, fe1, fe0;
   logic [7:0]  ec1, ec0;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          str1     = 0;
   int          s_base;

   lj16_deserializer #(.WIDTH(16), .LEFT_LEVEL(1)) dut1 (
      .bck(bck), .rst_n(rst_n), .lrck(lrck), .data(data),
      .left_data(l1), .right_data(r1), .sample_valid(v1),
      .frame_err(fe1), .err_count(ec1)
   );

   lj16_deserializer #(.WIDTH(16), .LEFT_LEVEL(0)) dut0 (
      .bck(bck), .rst_n(rst_n), .lrck(lrck), .data(data),
      .left_data(l0), .right_data(r0), .sample_valid(v0),
      .frame_err(fe0), .err_count(ec0)
   );

   initial bck = 1'b0;
   always #5 bck = ~bck;

   // ---------------- behavioural model ----------------
   // Tracks how many bits have arrived since the last LRCK edge; the word is
   // the first 16 of them, anything fewer is short, anything more is long.
   typedef struct {
      int          nbits;
      logic        started;
      logic        is_left;
      logic [15:0] word;
      logic [15:0] hold;
      logic        lok;
      logic [15:0] l;
      logic [15:0] r;
      logic        v;
      logic        fe;
      int          ec;
   } model_t;

   model_t ms1, ms0;
   logic   m_prev;
   logic   model_ok = 1'b0;

   function automatic model_t step(input model_t s, input logic lvl_left,
                                   input logic rst_now, input logic edg,
                                   input logic l_in, input logic d_in);
      model_t n;
      logic   err;
      n   = s;
      err = 1'b0;
      n.v = 1'b0;
      if (!rst_now) begin
         n.nbits = 0; n.started = 0; n.is_left = 0; n.word = 0; n.hold = 0;
         n.lok = 0; n.l = 0; n.r = 0; n.v = 0; n.fe = 0; n.ec = 0;
         return n;
      end
      if (edg) begin
         if (s.started && s.nbits < 16) begin
            err = 1'b1;
            if (s.is_left) n.lok = 1'b0;
         end
         n.started = 1'b1;
         n.nbits   = 1;
         n.is_left = (l_in == lvl_left);
         n.word    = {15'd0, d_in};
      end else if (s.started) begin
         n.nbits = s.nbits + 1;
         if (n.nbits <= 16) n.word = {s.word[14:0], d_in};
         else if (n.nbits == 17) err = 1'b1;
      end
      if (n.started && n.nbits == 16) begin
         if (n.is_left) begin
            n.hold = n.word;
            n.lok  = 1'b1;
         end else if (n.lok) begin
            n.l   = n.hold;
            n.r   = n.word;
            n.v   = 1'b1;
            n.lok = 1'b0;
         end
      end
      if (err && FEAT) begin
         n.fe = 1'b1;
         if (n.ec < 255) n.ec = n.ec + 1;
      end
      return n;
   endfunction

   // Model advances on the same rising edge the DUTs sample.
   always @(posedge bck) begin
      ms1    <= step(ms1, 1'b1, rst_n, lrck != m_prev, lrck, data);
      ms0    <= step(ms0, 1'b0, rst_n, lrck != m_prev, lrck, data);
      m_prev <= lrck;
      if (!rst_n) model_ok <= 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge bck);
         if (model_ok) begin
            chk("L1.left",  {16'd0, l1}, {16'd0, ms1.l});
            chk("L1.right", {16'd0, r1}, {16'd0, ms1.r});
            chk("L1.valid", {31'd0, v1}, {31'd0, ms1.v});
            chk("L1.ferr",  {31'd0, fe1}, {31'd0, ms1.fe});
            chk("L1.ecnt",  {24'd0, ec1}, ms1.ec);
            chk("L0.left",  {16'd0, l0}, {16'd0, ms0.l});
            chk("L0.right", {16'd0, r0}, {16'd0, ms0.r});
            chk("L0.valid", {31'd0, v0}, {31'd0, ms0.v});
            chk("L0.ferr",  {31'd0, fe0}, {31'd0, ms0.fe});
            chk("L0.ecnt",  {24'd0, ec0}, ms0.ec);
            if (v1 === 1'b1) str1++;
         end
      end
   end

   // ---------------- stimulus ----------------
   // One half-frame: nbits word bits MSB first, then extra '1' bits.
   // rst_at selects a bit during which rst_n is held low (-1: none).
   task automatic half(input logic lvl, input logic [15:0] w, input int nbits,
                       input int extra, input int rst_at);
      logic [15:0] wv;
      wv = w;
      for (int i = 0; i < nbits + extra; i++) begin
         lrck  = lvl;
         data  = (i < nbits) ? wv[15 - i] : 1'b1;
         rst_n = (i == rst_at) ? 1'b0 : 1'b1;
         @(negedge bck);
         if (i == rst_at) begin
            #1;
            chk("rst.left",  {16'd0, l1}, 32'h0);
            chk("rst.right", {16'd0, r1}, 32'h0);
            chk("rst.valid", {31'd0, v1}, 32'h0);
            chk("rst.ecnt",  {24'd0, ec1}, 32'h0);
            chk("rst.l0",    {16'd0, l0}, 32'h0);
            $display("txn reset mid-word at bit %0d", i);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic pair_chk(input string name, input logic [15:0] el, input logic [15:0] er,
                           input int estr);
      #1;
      chk({name, ".left"},    {16'd0, l1}, {16'd0, el});
      chk({name, ".right"},   {16'd0, r1}, {16'd0, er});
      chk({name, ".strobes"}, str1 - s_base, estr);
      $display("txn %s left=%h right=%h strobes=%0d err_count=%0d", name, l1, r1,
               str1 - s_base, ec1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      lrck  = 1'b0;
      data  = 1'b0;
      repeat (2) @(negedge bck);
      #1;
      chk("reset.left",  {16'd0, l1}, 32'h0);
      chk("reset.right", {16'd0, r1}, 32'h0);
      chk("reset.valid", {31'd0, v1}, 32'h0);
      chk("reset.ferr",  {31'd0, fe1}, 32'h0);
      chk("reset.ecnt",  {24'd0, ec1}, 32'h0);
      $display("txn reset outputs left=%h right=%h valid=%b", l1, r1, v1);

      // Idle on the right level, then one clean frame.
      half(1'b0, 16'h0000, 3, 0, -1);
      s_base = str1;
      half(1'b1, 16'hA55A, 16, 0, -1);
      half(1'b0, 16'h1234, 16, 0, -1);
      pair_chk("basic", 16'hA55A, 16'h1234, 1);
      chk("basic.valid", {31'd0, v1}, 32'h1);

      // Reset, then start mid-way through a right word.
      half(1'b0, 16'h0000, 1, 0, 0);
      half(1'b0, 16'hBEEF, 7, 0, -1);
      s_base = str1;
      half(1'b1, 16'h8001, 16, 0, -1);
      half(1'b0, 16'h7FFE, 16, 0, -1);
      pair_chk("midstart", 16'h8001, 16'h7FFE, 1);

      // Left word cut to 10 bits: no strobe, outputs keep prior pair.
      s_base = str1;
      half(1'b1, 16'h3C3C, 10, 0, -1);
      half(1'b0, 16'hFFFF, 16, 0, -1);
      pair_chk("shortleft", 16'h8001, 16'h7FFE, 0);
      chk("shortleft.ferr", {31'd0, fe1}, FEAT ? 32'd1 : 32'd0);
      chk("shortleft.ecnt", {24'd0, ec1}, FEAT ? 32'd1 : 32'd0);

      // 20 bck per half: pair still delivered, two long words per frame.
      s_base = str1;
      half(1'b1, 16'h00FF, 16, 4, -1);
      half(1'b0, 16'hFF00, 16, 4, -1);
      pair_chk("long", 16'h00FF, 16'hFF00, 1);
      chk("long.ecnt", {24'd0, ec1}, FEAT ? 32'd3 : 32'd0);
      for (int f = 0; f < 127; f++) begin
         half(1'b1, 16'h00FF, 16, 4, -1);
         half(1'b0, 16'hFF00, 16, 4, -1);
      end
      pair_chk("longsat", 16'h00FF, 16'hFF00, 128);
      chk("longsat.ecnt", {24'd0, ec1}, FEAT ? 32'd255 : 32'd0);
      chk("longsat.ferr", {31'd0, fe1}, FEAT ? 32'd1 : 32'd0);

      // Reset during bit 8 of a right word, then a clean frame.
      s_base = str1;
      half(1'b1, 16'h1357, 16, 0, -1);
      half(1'b0, 16'h2468, 16, 0, 8);
      half(1'b1, 16'h0F0F, 16, 0, -1);
      half(1'b0, 16'hF0F0, 16, 0, -1);
      pair_chk("midreset", 16'h0F0F, 16'hF0F0, 1);
      chk("midreset.ecnt", {24'd0, ec1}, 32'h0);

      // Low-level words are left for the LEFT_LEVEL=0 instance.
      s_base = str1;
      half(1'b1, 16'hAAAA, 16, 0, -1);
      half(1'b0, 16'h1111, 16, 0, -1);
      half(1'b1, 16'h2222, 16, 0, -1);
      pair_chk("lvl1", 16'hAAAA, 16'h1111, 1);
      chk("lvl0.left",  {16'd0, l0}, 32'h1111);
      chk("lvl0.right", {16'd0, r0}, 32'h2222);
      $display("txn lvl0 left=%h right=%h", l0, r0);

      half(1'b1, 16'h0000, 0, 3, -1);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lj16_deserializer.md
Name: lj16_deserializer

Overview:
Downstream consumer of the 16-bit left-justified serial stream produced by the 32LJ-to-16LJ stage. Samples data on the rising edge of the halved bit clock, frames words by LRCK edges, and presents a coherent left/right 16-bit sample pair on parallel outputs with a one-cycle valid strobe. Feeds the parallel DSP/volume path.

Parameters:
WIDTH, 16, bits per channel word; MSB-first, left-justified.
LEFT_LEVEL, 1, lrck level that denotes the left channel.

Ports:
bck  input  1  bit clock (the 16LJ bck_out); all logic on rising edge.
rst_n  input  1  reset; synchronous, active-low.
lrck  input  1  word clock; changes on falling bck.
data  input  1  serial data, MSB first; changes on falling bck.
left_data  output  WIDTH  last complete left word.
right_data  output  WIDTH  last complete right word.
sample_valid  output  1  one-cycle pulse, new pair on left_data/right_data.
frame_err  output  1  sticky framing error (feature only; 0 otherwise).
err_count  output  8  framing-error count (feature only; 0 otherwise).

Behaviour:
- Reset (rst_n=0 at rising bck): left_data=0, right_data=0, sample_valid=0, frame_err=0, err_count=0, internal shift/holding regs=0, bit counter=0, left_ok=0, lrck_d=lrck sampled that edge, state=SYNC.
- LRCK edge = lrck != lrck_d at a rising bck; data sampled on that same edge is the word MSB. Channel = lrck level at that edge (== LEFT_LEVEL -> left).
- States: SYNC (after reset; ignore data until first LRCK edge) -> SHIFT; SHIFT (collect bits) -> DONE when WIDTH-th bit taken; DONE (ignore further bits) -> SHIFT on next LRCK edge. An LRCK edge in SHIFT also -> SHIFT (new word, old one discarded).
- On LRCK edge: shift = {0..., data}, cnt=1. In SHIFT, no edge: shift = {shift[WIDTH-2:0], data}, cnt+1. Word complete on edge where cnt becomes WIDTH.
- Left complete: store in left_hold, left_ok=1. Right complete with left_ok=1: left_data<=left_hold, right_data<=assembled word, sample_valid=1 for exactly one bck cycle, left_ok=0. Right complete with left_ok=0 (first frame started on right, or short left): word discarded, no strobe.
- Latency: sample_valid high in the bck cycle after the edge that samples the right LSB; outputs hold until next strobe.
- Short word (LRCK edge while SHIFT, cnt<WIDTH): partial word discarded; if left, left_ok=0.
- Long word (bits after WIDTH before next edge): ignored in DONE.
- Counter cnt is 5 bits, saturates at WIDTH; never wraps.
- Reset mid-word: immediate return to SYNC, outputs cleared, partial data lost.

Optional Feature:
LJ16_FRAME_CHECK_EN. Defined: short word or long word (any bit sampled in DONE before next LRCK edge, counted once per word) sets frame_err (sticky until reset) and increments err_count, saturating at 255. Short and long in same word counts once. Undefined: no checking logic; frame_err and err_count tied 0; data path behaviour identical.

Test Plan:
- Reset then frames L=0xA55A, R=0x1234 (16 bck/half, LEFT_LEVEL=1) -> first strobe after first full pair; left_data=0xA55A, right_data=0x1234, sample_valid high exactly 1 cycle.
- Stream starts mid-right word after reset -> partial right ignored, no strobe until next complete L=0x8001,R=0x7FFE pair; then outputs those values.
- Left half cut to 10 bits, then R=0xFFFF -> no strobe for that frame, outputs keep prior values; with LJ16_FRAME_CHECK_EN frame_err=1, err_count=1.
- 20 bck per half, L=0x00FF, R=0xFF00 + 4 extra bits 1 -> pair 0x00FF/0xFF00 delivered; with feature err_count increments by 2 per frame, saturates at 255 after 128 frames.
- rst_n low for one cycle at bit 8 of right word -> all outputs 0 next cycle, no strobe; next full pair L=0x0F0F,R=0xF0F0 delivered correctly.
- LEFT_LEVEL=0, lrck low carries 0x1111, high 0x2222 -> left_data=0x1111, right_data=0x2222.
